fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter data_width, default 32, meaning FIFO/stream data width in bits.
REQ-002 The block SHALL have parameter burst_len, default 16, meaning beats per burst (power of 2, 2..256).
REQ-003 The block SHALL have parameter frame_beats, default 1024, meaning beats per frame (>= 1, any value).
REQ-004 The block SHALL have parameter cnt_width, default 6, meaning width of the FIFO data_cnt input (capable of holding burst_len).
REQ-005 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port en  input  1  level enable; burst starts are allowed only while high.
REQ-008 The block SHALL have port fifo_ren  output  1  read strobe to the upstream first-word-fall-through FIFO.
REQ-009 The block SHALL have port fifo_dout  input  data_width  FIFO head word, valid while fifo_empty_n=1.
REQ-010 The block SHALL have port fifo_empty_n  input  1  FIFO non-empty flag.
REQ-011 The block SHALL have port data_cnt  input  cnt_width  FIFO stored-word count.
REQ-012 The block SHALL have port m_axis_tdata  output  data_width  stream data.
REQ-013 The block SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-014 The block SHALL have port m_axis_tready  input  1  stream ready.
REQ-015 The block SHALL have port m_axis_tlast  output  1  last beat of the current burst.
REQ-016 The block SHALL have port m_axis_tuser  output  1  first beat of a frame.
REQ-017 The block SHALL have port frame_done  output  1  one-cycle pulse when the final frame beat is accepted downstream.

Function
REQ-018 The block SHALL implement FSM states IDLE, BURST, DRAIN.
REQ-019 In IDLE, cur_len SHALL equal min(burst_len, frame beats remaining); IDLE->BURST SHALL occur when en=1 and data_cnt >= cur_len.
REQ-020 In BURST, fifo_ren SHALL equal fifo_empty_n & (~m_axis_tvalid | m_axis_tready) & (reads issued < cur_len).
REQ-021 A read SHALL load fifo_dout into the registered output stage on the same edge, so tvalid is asserted 1 cycle after fifo_ren.
REQ-022 The output register SHALL hold tdata/tlast/tuser stable while tvalid=1 and tready=0.
REQ-023 BURST->DRAIN SHALL occur on the edge issuing the cur_len-th read; DRAIN->IDLE SHALL occur when the tlast beat is accepted (tvalid & tready & tlast).
REQ-024 tlast SHALL be set on the cur_len-th beat of each burst only.
REQ-025 tuser SHALL be set only on frame beat 0.
REQ-026 The frame beat counter SHALL increment per accepted beat and wrap to 0 after frame_beats-1; frame_done SHALL pulse on that accept edge.
REQ-027 When frame_beats is not a multiple of burst_len, the last burst of the frame SHALL be short (frame_beats mod burst_len beats) with tlast set.
REQ-028 fifo_ren SHALL never be asserted when fifo_empty_n=0; an empty FIFO mid-burst SHALL stall without ending the burst.
REQ-029 Deasserting en SHALL NOT truncate a burst in progress; the block SHALL return to IDLE after the burst and then wait.
REQ-030 In IDLE, a beat from the previous burst still held in the output register SHALL be impossible (DRAIN guarantees this).

Reset
REQ-031 On rst=1, regardless of clk, the block SHALL force state IDLE, all counters 0, m_axis_tvalid=0, tlast=0, tuser=0, frame_done=0, fifo_ren=0, and tdata=0.
REQ-032 Reset mid-burst SHALL discard the partial burst; the next frame after release SHALL start with tuser=1 at beat 0.

Verification
REQ-033 burst_len=16, frame_beats=64, data_cnt=16, tready=1, en=1 -> four bursts of 16 beats, tlast on beats 15/31/47/63, tuser on beat 0 only, one frame_done.
REQ-034 Threshold: data_cnt=15 held -> no fifo_ren and tvalid=0 in IDLE; data_cnt=16 -> fifo_ren high next cycle, tvalid 1 cycle later.
REQ-035 tready toggled in a 1,0 pattern -> no beats lost or duplicated, tdata stable during stall, data order equals FIFO write order.
REQ-036 frame_beats=40, burst_len=16 -> bursts of 16,16,8; tlast on beat 39; frame_done pulse on its accept; next beat has tuser=1.
REQ-037 Reset asserted mid-burst at beat 5 -> tvalid=0 and fifo_ren=0 immediately; after release, first accepted beat has tuser=1.
REQ-038 en dropped at beat 3 of a burst -> burst completes through tlast, then no further fifo_ren while en=0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Reads fixed-length bursts from a first-word-fall-through FIFO and presents
// them on an AXI4-Stream master port. A burst starts only when the FIFO
// already holds the whole burst, so a started burst normally streams without
// gaps. Bursts are aligned to frames: the final burst of a frame is shortened
// to the frame remainder. tuser marks frame beat 0, tlast marks the last beat
// of every burst, and frame_done pulses once the last frame beat is accepted.
//
// Handshake: a beat moves downstream on any rising edge where
// m_axis_tvalid=1 and m_axis_tready=1. Once tvalid is high, tdata, tlast and
// tuser hold their values until that edge. A FIFO word is consumed on any
// rising edge where fifo_ren=1, and fifo_ren is only raised while
// fifo_empty_n=1.
module fifo_burst_reader #(
  parameter int data_width  = 32,
  parameter int burst_len   = 16,
  parameter int frame_beats = 1024,
  parameter int cnt_width   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_ren,
  input  logic [data_width-1:0] fifo_dout,
  input  logic                  fifo_empty_n,
  input  logic [cnt_width-1:0]  data_cnt,
  output logic [data_width-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  // Burst length counters must be able to hold burst_len itself.
  localparam int LW = $clog2(burst_len + 1);
  // Frame beat counter; at least one bit even for single-beat frames.
  localparam int FW = (frame_beats > 1) ? $clog2(frame_beats) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_cur_len;      // length of the burst in progress
  logic [LW-1:0]   r_reads;        // FIFO reads issued in this burst
  logic [FW-1:0]   r_frame_cnt;    // accepted beats in the current frame
  logic            r_first_burst;  // current burst begins at frame beat 0
  logic            r_frame_done;
  logic [data_width-1:0] r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_tuser;

  logic [31:0]     w_remaining;
  logic [LW-1:0]   w_cur_len;
  logic            w_start;
  logic            w_ren;
  logic            w_last_read;
  logic            w_accept;
  logic            w_frame_end;

  // Length of the next burst: a full burst, or the frame remainder if shorter.
  // Only meaningful in IDLE, where every issued beat has also been accepted,
  // so the accepted-beat count is the true frame position.
  always_comb begin
    w_remaining = 32'(frame_beats) - 32'(r_frame_cnt);
    if (w_remaining < 32'(burst_len)) begin
      w_cur_len = LW'(w_remaining);
    end else begin
      w_cur_len = LW'(burst_len);
    end
  end

  // Burst start, FIFO read strobe and beat acceptance decodes.
  always_comb begin
    w_start     = (r_state == S_IDLE) && en &&
                  (32'(data_cnt) >= 32'(w_cur_len));
    // The output stage holds one word, so a read is allowed only when that
    // word is empty or leaving on this edge.
    w_ren       = (r_state == S_BURST) && fifo_empty_n &&
                  (!r_tvalid || m_axis_tready) && (r_reads < r_cur_len);
    w_last_read = w_ren && ((r_reads + LW'(1)) == r_cur_len);
    w_accept    = r_tvalid && m_axis_tready;
    w_frame_end = (r_frame_cnt == FW'(frame_beats - 1));
  end

  // Burst sequencing: IDLE waits for a full burst in the FIFO, BURST issues
  // the reads, DRAIN waits for the tlast beat to leave so IDLE always starts
  // with an empty output stage. en is sampled only in IDLE, so dropping it
  // never cuts a burst short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur_len     <= '0;
      r_reads       <= '0;
      r_first_burst <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_BURST;
            r_cur_len     <= w_cur_len;
            r_reads       <= '0;
            r_first_burst <= (r_frame_cnt == '0);
          end
        end
        S_BURST: begin
          if (w_ren) begin
            r_reads <= r_reads + LW'(1);
            if (w_last_read) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_accept && r_tlast) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output register: loads the FIFO head on a read, clears valid when the
  // beat is taken without a replacement, otherwise holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else if (w_ren) begin
      r_tdata  <= fifo_dout;
      r_tvalid <= 1'b1;
      r_tlast  <= w_last_read;
      r_tuser  <= r_first_burst && (r_reads == '0);
    end else if (w_accept) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end
  end

  // Frame position tracks accepted beats; frame_done is a one-cycle pulse
  // following the edge that accepts the final beat of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (w_frame_end) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  assign fifo_ren      = w_ren;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign frame_done    = r_frame_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader.
// Instance a: 16-beat bursts, 40-beat frames (16,16,8), driven from a model
// FWFT FIFO. Instance b: 16-beat bursts, 64-beat frames, endless source.
module tb_fifo_burst_reader;

  localparam int DW    = 16;
  localparam int BL    = 16;
  localparam int FR_A  = 40;
  localparam int FR_B  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // ---------------- instance a signals ----------------
  logic          en_a;
  logic          ren_a;
  logic [DW-1:0] dout_a;
  logic          empty_n_a;
  logic [5:0]    cnt_a;
  logic [DW-1:0] tdata_a;
  logic          tvalid_a;
  logic          tready_a;
  logic          tlast_a;
  logic          tuser_a;
  logic          fd_a;
  logic [1:0]    st_a;

  // ---------------- instance b signals ----------------
  logic          en_b;
  logic          ren_b;
  logic [DW-1:0] src_b;
  logic [DW-1:0] tdata_b;
  logic          tvalid_b;
  logic          tlast_b;
  logic          tuser_b;
  logic          fd_b;
  logic [1:0]    st_b;
  logic          one_b;
  logic [5:0]    cnt_b;

  assign one_b = 1'b1;
  assign cnt_b = 6'd16;

  fifo_burst_reader #(.data_width(DW), .burst_len(BL), .frame_beats(FR_A), .cnt_width(6)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .fifo_ren(ren_a), .fifo_dout(dout_a),
    .fifo_empty_n(empty_n_a), .data_cnt(cnt_a), .m_axis_tdata(tdata_a),
    .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a), .m_axis_tlast(tlast_a),
    .m_axis_tuser(tuser_a), .frame_done(fd_a), .dbg_state(st_a)
  );

  fifo_burst_reader #(.data_width(DW), .burst_len(BL), .frame_beats(FR_B), .cnt_width(6)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .fifo_ren(ren_b), .fifo_dout(src_b),
    .fifo_empty_n(one_b), .data_cnt(cnt_b), .m_axis_tdata(tdata_b),
    .m_axis_tvalid(tvalid_b), .m_axis_tready(one_b), .m_axis_tlast(tlast_b),
    .m_axis_tuser(tuser_b), .frame_done(fd_b), .dbg_state(st_b)
  );

  // ---------------- FIFO model for instance a ----------------
  logic [DW-1:0] mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;

  assign empty_n_a = (wr_ptr != rd_ptr);
  assign cnt_a     = ((wr_ptr - rd_ptr) > 63) ? 6'd63 : 6'(wr_ptr - rd_ptr);
  assign dout_a    = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (ren_a) rd_ptr <= rd_ptr + 1;
  end

  // Endless counting source for instance b.
  always @(posedge clk or posedge rst) begin
    if (rst) src_b <= '0;
    else if (ren_b) src_b <= src_b + 16'd1;
  end

  // ---------------- scoreboard / checking ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_a    = 0;
  int idx_b    = 0;
  int fd_cnt_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom_range(0, 65535));
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
      exp_q.push_back(w);
    end
  endtask

  // Output monitor, sampled on the falling edge (inputs change just after
  // the rising edge, so what is seen here is what the next edge acts on).
  initial begin : monitor
    int fb;
    bit pend_fd;
    bit hold_v;
    logic [DW-1:0] hold_d;
    logic hold_l, hold_u;
    logic [DW-1:0] e;
    fb = 0; pend_fd = 0; hold_v = 0; hold_d = '0; hold_l = 0; hold_u = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fb = 0; pend_fd = 0; hold_v = 0;
        exp_q.delete();
      end else begin
        if (pend_fd || fd_a) chk("frame_done_a", fd_a, pend_fd);
        pend_fd = 0;
        if (ren_a) chk("ren_only_when_nonempty", empty_n_a, 1);
        if (hold_v) begin
          chk("stall_tvalid", tvalid_a, 1);
          chk("stall_tdata", tdata_a, hold_d);
          chk("stall_tlast", tlast_a, hold_l);
          chk("stall_tuser", tuser_a, hold_u);
        end
        hold_v = tvalid_a && !tready_a;
        hold_d = tdata_a; hold_l = tlast_a; hold_u = tuser_a;
        if (tvalid_a && tready_a) begin
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tdata_a", tdata_a, e);
          end
          chk("tlast_a", tlast_a, ((fb % BL) == BL - 1) || (fb == FR_A - 1));
          chk("tuser_a", tuser_a, fb == 0);
          if (fb == FR_A - 1) pend_fd = 1;
          fb = (fb + 1) % FR_A;
          acc_a++;
        end
        // instance b: always ready
        if (fd_b) fd_cnt_b++;
        if (tvalid_b) begin
          chk("tdata_b", tdata_b, DW'(idx_b));
          chk("tlast_b", tlast_b, (idx_b % BL) == BL - 1);
          chk("tuser_b", tuser_b, (idx_b % FR_B) == 0);
          idx_b++;
        end
      end
    end
  end

  // Instance b: one frame, en dropped inside the last burst.
  initial begin : drive_b
    int n;
    en_b = 1'b0;
    wait (rst === 1'b0);
    @(posedge clk); #1;
    en_b = 1'b1;
    n = 0;
    while (idx_b < 50 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk("timeout_b", 0, 1);
    en_b = 1'b0;
  end

  // Drive tready by mode and wait for the scoreboard to drain.
  task automatic run_drain(input int mode);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 3000) begin
      case (mode)
        0: tready_a = 1'b1;
        1: tready_a = ~tready_a;
        default: tready_a = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1; n++;
      done = (exp_q.size() == 0) && !tvalid_a;
    end
    if (!done) chk("timeout_drain", 0, 1);
    tready_a = 1'b1;
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_a < target && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (acc_a < target) chk("timeout_acc", acc_a, target);
  endtask

  typedef struct {
    int         push;
    bit         en;
    bit         rdy;
    int         cyc;
    bit         exp_ren;
    bit         exp_tvalid;
    logic [1:0] exp_state;
  } vec_t;

  initial begin : main
    vec_t vt[5];
    int   base;
    int   n;
    bit   ren_seen;

    vt[0] = '{push: 15, en: 1, rdy: 0, cyc: 3, exp_ren: 0, exp_tvalid: 0, exp_state: 2'd0};
    vt[1] = '{push: 1,  en: 0, rdy: 0, cyc: 3, exp_ren: 0, exp_tvalid: 0, exp_state: 2'd0};
    vt[2] = '{push: 0,  en: 1, rdy: 0, cyc: 1, exp_ren: 1, exp_tvalid: 0, exp_state: 2'd1};
    vt[3] = '{push: 0,  en: 1, rdy: 0, cyc: 1, exp_ren: 0, exp_tvalid: 1, exp_state: 2'd1};
    vt[4] = '{push: 0,  en: 1, rdy: 0, cyc: 3, exp_ren: 0, exp_tvalid: 1, exp_state: 2'd1};

    en_a = 1'b0; tready_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid_a, 0);
    chk("rst_ren", ren_a, 0);
    chk("rst_tlast", tlast_a, 0);
    chk("rst_tuser", tuser_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_tdata", tdata_a, 0);
    chk("rst_state", st_a, 0);
    rst = 1'b0;

    // Threshold and first-read latency.
    for (int i = 0; i < 5; i++) begin
      push_words(vt[i].push);
      en_a = vt[i].en;
      tready_a = vt[i].rdy;
      repeat (vt[i].cyc) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ren", i), ren_a, vt[i].exp_ren);
      chk($sformatf("vec%0d_tvalid", i), tvalid_a, vt[i].exp_tvalid);
      chk($sformatf("vec%0d_state", i), st_a, vt[i].exp_state);
    end

    // Rest of frame 1 (16 + 8) with tready toggling 1,0.
    tready_a = 1'b0;
    push_words(24);
    run_drain(1);

    // Frame 2 with random backpressure.
    push_words(40);
    run_drain(2);

    // en dropped at beat 3 of a burst: burst still finishes.
    base = acc_a;
    push_words(16);
    tready_a = 1'b1;
    wait_acc(base + 3);
    en_a = 1'b0;
    push_words(16);
    n = 0;
    while (!(exp_q.size() == 16 && !tvalid_a) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("en_drop_burst_complete", exp_q.size(), 16);
    ren_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      ren_seen |= ren_a;
    end
    chk("en_low_no_ren", ren_seen, 0);
    chk("en_low_idle", st_a, 0);
    en_a = 1'b1;
    run_drain(0);

    // Reset at beat 5 of the short 8-beat burst (frame position 32).
    base = acc_a;
    push_words(8);
    wait_acc(base + 5);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", tvalid_a, 0);
    chk("midrst_ren", ren_a, 0);
    chk("midrst_state", st_a, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_words(40);
    run_drain(2);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("b_beats", idx_b, FR_B);
    chk("b_frame_done_count", fd_cnt_b, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
